// File: rtl/add_pg_pipe.sv
// add_pg_pipe: pipelined group propagate/generate adder/subtractor.
//
// Computes val1 + val2 + carry_in (sub=0) or val1 - val2 with carry_in as an
// inverted borrow-in (sub=1). The word is split into STAGES equal slices and
// each pipeline stage resolves one slice from the carry registered by the
// stage before it. Input and output use valid/ready handshakes, and a stage
// may load whenever it is empty or the stage after it is moving.
//
// Ports:
//   clk, rst_n            clock, asynchronous active-low reset
//   in_valid / in_ready   operand beat handshake
//   val1, val2            operands (WIDTH bits)
//   carry_in, sub         carry/borrow in, 0 = add / 1 = subtract
//   out_valid / out_ready result beat handshake
//   val_out               sum or difference (WIDTH bits)
//   carry_out             carry out of the MSB (1 = no borrow when subtracting)
//   overflow              signed two's-complement overflow
//   zero                  val_out == 0
//   prop_out, gen_out     word-level group propagate / generate
module add_pg_pipe #(
  parameter int WIDTH  = 32,
  parameter int STAGES = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] val1,
  input  logic [WIDTH-1:0] val2,
  input  logic             carry_in,
  input  logic             sub,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] val_out,
  output logic             carry_out,
  output logic             overflow,
  output logic             zero,
  output logic             prop_out,
  output logic             gen_out
);

  localparam int SW  = WIDTH / STAGES;
  localparam int MSB = WIDTH - 1;

  // Index k of each *_pipe array is what stage k consumes; index k+1 is
  // what stage k has registered. Operands are not needed past the last stage.
  logic [STAGES-1:0][WIDTH-1:0] a_pipe;
  logic [STAGES-1:0][WIDTH-1:0] b_pipe;
  logic [STAGES:0][WIDTH-1:0]   s_pipe;
  logic [STAGES:0]              c_pipe;
  logic [STAGES:0]              p_pipe;
  logic [STAGES:0]              g_pipe;
  logic [STAGES:0]              v_pipe;
  logic [STAGES-1:0]            rdy;
  logic [WIDTH-1:0]             s_last_d;
  logic                         last_ld;
  logic                         zero_d, zero_q;
  logic                         ovf_d, ovf_q;

  // Effective operands: subtraction is a + ~b + ~borrow. The running P/G
  // starts at the identity (P=1, G=0) so prop/gen never see c0.
  assign a_pipe[0] = val1;
  assign b_pipe[0] = val2 ^ {WIDTH{sub}};
  assign s_pipe[0] = '0;
  assign c_pipe[0] = carry_in ^ sub;
  assign p_pipe[0] = 1'b1;
  assign g_pipe[0] = 1'b0;
  assign v_pipe[0] = in_valid;

  // ready_k = ~valid_k | ready_k+1, unrolled so each ready depends only on
  // out_ready and the valid bits: stage k can move unless every stage from
  // k to the output is full and the consumer is stalled.
  always_comb begin : ready_chain
    logic all_v;
    all_v = 1'b1;
    rdy   = '0;
    for (int k = STAGES - 1; k >= 0; k--) begin
      all_v  = all_v & v_pipe[k+1];
      rdy[k] = out_ready | ~all_v;
    end
  end

  assign in_ready = rdy[0];

  for (genvar k = 0; k < STAGES; k++) begin : g_stg
    localparam int LO = k * SW;

    logic [WIDTH-1:0] s_d, s_q;
    logic             c_d, c_q;
    logic             p_d, p_q;
    logic             g_d, g_q;
    logic             vld_d, vld_q;
    logic             ld;

    // Stage k: resolve slice k from the incoming carry; the slice carry-out
    // comes from the slice group P/G rather than the internal bit ripple.
    always_comb begin
      logic cc, pi, gi, sp, sg;
      s_d = s_pipe[k];
      cc  = c_pipe[k];
      sp  = 1'b1;
      sg  = 1'b0;
      pi  = 1'b0;
      gi  = 1'b0;
      for (int i = 0; i < SW; i++) begin
        pi           = a_pipe[k][LO+i] ^ b_pipe[k][LO+i];
        gi           = a_pipe[k][LO+i] & b_pipe[k][LO+i];
        s_d[LO+i]    = pi ^ cc;
        cc           = gi | (pi & cc);
        sg           = gi | (pi & sg);
        sp           = sp & pi;
      end
      c_d   = sg | (sp & c_pipe[k]);
      p_d   = sp & p_pipe[k];
      g_d   = sg | (sp & g_pipe[k]);
      ld    = rdy[k] & v_pipe[k];
      vld_d = rdy[k] ? v_pipe[k] : vld_q;
    end

    // Data only moves with a real beat, so a stalled or drained output holds.
    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
        vld_q <= 1'b0;
        s_q   <= '0;
        c_q   <= 1'b0;
        p_q   <= 1'b0;
        g_q   <= 1'b0;
      end else begin
        vld_q <= vld_d;
        if (ld) begin
          s_q <= s_d;
          c_q <= c_d;
          p_q <= p_d;
          g_q <= g_d;
        end
      end
    end

    assign s_pipe[k+1] = s_q;
    assign c_pipe[k+1] = c_q;
    assign p_pipe[k+1] = p_q;
    assign g_pipe[k+1] = g_q;
    assign v_pipe[k+1] = vld_q;

    if (k < STAGES - 1) begin : g_pass
      logic [WIDTH-1:0] a_q, b_q;

      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
          a_q <= '0;
          b_q <= '0;
        end else if (ld) begin
          a_q <= a_pipe[k];
          b_q <= b_pipe[k];
        end
      end

      assign a_pipe[k+1] = a_q;
      assign b_pipe[k+1] = b_q;
    end else begin : g_last
      assign s_last_d = s_d;
    end
  end

  // Final stage: zero and overflow need the complete result word.
  assign last_ld = rdy[STAGES-1] & v_pipe[STAGES-1];

  always_comb begin
    zero_d = (s_last_d == '0);
    ovf_d  = (a_pipe[STAGES-1][MSB] == b_pipe[STAGES-1][MSB]) &
             (s_last_d[MSB] != a_pipe[STAGES-1][MSB]);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      zero_q <= 1'b0;
      ovf_q  <= 1'b0;
    end else if (last_ld) begin
      zero_q <= zero_d;
      ovf_q  <= ovf_d;
    end
  end

  assign out_valid = v_pipe[STAGES];
  assign val_out   = s_pipe[STAGES];
  assign carry_out = c_pipe[STAGES];
  assign prop_out  = p_pipe[STAGES];
  assign gen_out   = g_pipe[STAGES];
  assign zero      = zero_q;
  assign overflow  = ovf_q;

endmodule

// File: tb/tb_add_pg_pipe.sv
// Bench for add_pg_pipe: three instances (32/2, 32/1, 64/4) share one set of
// stimulus signals; sel picks which one is driven and observed while the
// others idle with out_ready held high.
module tb_add_pg_pipe;

  typedef struct packed {
    logic [63:0] val;
    logic [4:0]  fl;   // {carry, overflow, zero, prop, gen}
  } exp_t;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [1:0]  sel;
  logic        in_valid, out_ready, cin, sb;
  logic [63:0] v1, v2;

  int   checks = 0;
  int   errors = 0;
  int   n_acc  = 0;
  exp_t expq[$];

  always #5 clk = ~clk;

  logic        ir_a, ov_a, co_a, of_a, z_a, p_a, g_a;
  logic [31:0] vo_a;
  logic        ir_b, ov_b, co_b, of_b, z_b, p_b, g_b;
  logic [31:0] vo_b;
  logic        ir_c, ov_c, co_c, of_c, z_c, p_c, g_c;
  logic [63:0] vo_c;

  add_pg_pipe #(.WIDTH(32), .STAGES(2)) u_a (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & (sel == 2'd0)), .in_ready(ir_a),
    .val1(v1[31:0]), .val2(v2[31:0]), .carry_in(cin), .sub(sb),
    .out_valid(ov_a), .out_ready(out_ready | (sel != 2'd0)), .val_out(vo_a),
    .carry_out(co_a), .overflow(of_a), .zero(z_a), .prop_out(p_a), .gen_out(g_a));

  add_pg_pipe #(.WIDTH(32), .STAGES(1)) u_b (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & (sel == 2'd1)), .in_ready(ir_b),
    .val1(v1[31:0]), .val2(v2[31:0]), .carry_in(cin), .sub(sb),
    .out_valid(ov_b), .out_ready(out_ready | (sel != 2'd1)), .val_out(vo_b),
    .carry_out(co_b), .overflow(of_b), .zero(z_b), .prop_out(p_b), .gen_out(g_b));

  add_pg_pipe #(.WIDTH(64), .STAGES(4)) u_c (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid & (sel == 2'd2)), .in_ready(ir_c),
    .val1(v1), .val2(v2), .carry_in(cin), .sub(sb),
    .out_valid(ov_c), .out_ready(out_ready | (sel != 2'd2)), .val_out(vo_c),
    .carry_out(co_c), .overflow(of_c), .zero(z_c), .prop_out(p_c), .gen_out(g_c));

  logic        o_valid, o_ready;
  logic [63:0] o_val;
  logic [4:0]  o_fl;

  always_comb begin
    case (sel)
      2'd1: begin
        o_valid = ov_b; o_ready = ir_b; o_val = {32'd0, vo_b};
        o_fl = {co_b, of_b, z_b, p_b, g_b};
      end
      2'd2: begin
        o_valid = ov_c; o_ready = ir_c; o_val = vo_c;
        o_fl = {co_c, of_c, z_c, p_c, g_c};
      end
      default: begin
        o_valid = ov_a; o_ready = ir_a; o_val = {32'd0, vo_a};
        o_fl = {co_a, of_a, z_a, p_a, g_a};
      end
    endcase
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Reference: plain wide arithmetic on the effective operands. Overflow is
  // judged by whether the true signed sum fits in w bits; generate is the
  // carry out with c0 forced to 0, propagate is "every bit differs".
  function automatic exp_t model(int w, logic [63:0] a_in, logic [63:0] b_in,
                                 logic ci, logic s);
    logic [64:0]        mask, a, bf, sum, sum0;
    logic signed [66:0] sa, sbv, ss, lim;
    logic               c0;
    exp_t               r;
    mask = (65'd1 << w) - 65'd1;
    a    = {1'b0, a_in} & mask;
    bf   = (s ? ~{1'b0, b_in} : {1'b0, b_in}) & mask;
    c0   = ci ^ s;
    sum  = a + bf + {64'd0, c0};
    sum0 = a + bf;
    lim  = 67'sd1 <<< (w - 1);
    sa   = $signed({2'b00, a});
    if (a[w-1]) sa = sa - (lim <<< 1);
    sbv  = $signed({2'b00, bf});
    if (bf[w-1]) sbv = sbv - (lim <<< 1);
    ss   = sa + sbv + $signed({66'd0, c0});
    r.val = sum[63:0] & mask[63:0];
    r.fl  = {sum[w], (ss >= lim) || (ss < -lim), (sum & mask) == 65'd0,
             (a ^ bf) == mask, sum0[w]};
    return r;
  endfunction

  function automatic exp_t mk(logic [63:0] val, logic [4:0] fl);
    exp_t r;
    r.val = val;
    r.fl  = fl;
    return r;
  endfunction

  function automatic logic [63:0] pick();
    case ($urandom_range(0, 5))
      0:       return '1;
      1:       return '0;
      2:       return 64'h8000_0000_8000_0000;
      3:       return 64'h7FFF_FFFF_7FFF_FFFF;
      default: return {$urandom, $urandom};
    endcase
  endfunction

  function automatic int w_of(logic [1:0] s);
    return (s == 2'd2) ? 64 : 32;
  endfunction

  function automatic int st_of(logic [1:0] s);
    return (s == 2'd2) ? 4 : ((s == 2'd1) ? 1 : 2);
  endfunction

  // Offer one beat from a falling edge and hold it until accepted.
  task automatic send(input logic [63:0] a, input logic [63:0] b,
                      input logic ci, input logic s, input exp_t e);
    int n;
    @(negedge clk);
    v1 = a; v2 = b; cin = ci; sb = s; in_valid = 1'b1;
    #1;
    n = 0;
    while (!o_ready && n < 50) begin
      @(negedge clk);
      #1;
      n++;
    end
    if (!o_ready) begin
      chk("accept_timeout", 64'd0, 64'd1);
      in_valid = 1'b0;
    end else begin
      expq.push_back(e);
      @(posedge clk);
      #1;
      n_acc++;
      in_valid = 1'b0;
    end
  endtask

  task automatic send_rand();
    logic [63:0] a, b;
    logic        ci, s;
    a  = pick();
    b  = pick();
    ci = 1'($urandom_range(0, 1));
    s  = 1'($urandom_range(0, 1));
    send(a, b, ci, s, model(w_of(sel), a, b, ci, s));
  endtask

  task automatic drain();
    int n;
    @(negedge clk);
    out_ready = 1'b1;
    n = 0;
    while (expq.size() != 0 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("drain_empty", 64'(expq.size()), 64'd0);
  endtask

  // Checks every beat the consumer takes against the expected queue.
  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      #2;
      if (rst_n && o_valid && out_ready) begin
        if (expq.size() == 0) begin
          chk("spurious_beat", 64'd1, 64'd0);
        end else begin
          e = expq.pop_front();
          chk("val_out", o_val, e.val);
          chk("flags", 64'(o_fl), 64'(e.fl));
        end
      end
    end
  endtask

  task automatic stall_test();
    int st;
    st    = st_of(sel);
    n_acc = 0;
    @(negedge clk);
    out_ready = 1'b0;
    fork
      begin
        for (int i = 0; i < 4; i++) send_rand();
      end
      begin
        logic [63:0] hv;
        logic        hvld;
        hvld = 1'b0;
        hv   = '0;
        for (int c = 0; c < 6; c++) begin
          @(negedge clk);
          #3;
          chk("stall_in_ready", 64'(o_ready), 64'(n_acc < st));
          if (hvld) chk("stall_hold", o_val, hv);
          if (o_valid) begin
            hv   = o_val;
            hvld = 1'b1;
          end
        end
        @(negedge clk);
        out_ready = 1'b1;
      end
    join
    drain();
  endtask

  task automatic rand_test(input int nb);
    bit done;
    done = 1'b0;
    fork
      begin
        for (int i = 0; i < nb; i++) begin
          if ($urandom_range(0, 3) == 0) @(negedge clk);
          send_rand();
        end
        done = 1'b1;
      end
      begin
        while (!done) begin
          @(negedge clk);
          out_ready = ($urandom_range(0, 3) != 0);
        end
      end
    join
    drain();
  endtask

  initial begin
    int lat;
    rst_n = 1'b0; sel = 2'd0; in_valid = 1'b0; out_ready = 1'b1;
    v1 = '0; v2 = '0; cin = 1'b0; sb = 1'b0;
    fork
      monitor_loop();
    join_none

    repeat (2) @(negedge clk);
    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      #1;
      chk("rst_valid", 64'(o_valid), 64'd0);
      chk("rst_val", o_val, 64'd0);
      chk("rst_flags", 64'(o_fl), 64'd0);
    end
    sel = 2'd0;
    @(negedge clk);
    rst_n = 1'b1;
    #1;
    chk("rst_in_ready", 64'(o_ready), 64'd1);

    // Directed vectors on the 32-bit, 2-stage instance.
    send(64'hFFFF_FFFF, 64'h1, 1'b0, 1'b0, mk(64'h0, 5'b10101));
    lat = 1;
    while (!o_valid && lat < 10) begin
      @(posedge clk);
      #1;
      lat++;
    end
    chk("latency", 64'(lat), 64'd2);
    drain();
    send(64'h0000_FFFF, 64'h1,         1'b0, 1'b0, mk(64'h0001_0000, 5'b00000));
    send(64'h0,         64'hFFFF_FFFF, 1'b1, 1'b0, mk(64'h0,         5'b10110));
    send(64'h5,         64'h7,         1'b0, 1'b1, mk(64'hFFFF_FFFE, 5'b00000));
    send(64'h8000_0000, 64'h1,         1'b0, 1'b1, mk(64'h7FFF_FFFF, 5'b11001));
    send(64'h7FFF_FFFF, 64'h1,         1'b0, 1'b0, mk(64'h8000_0000, 5'b01000));
    drain();

    for (int s = 0; s < 3; s++) begin
      sel = 2'(s);
      stall_test();
      rand_test(60);
    end

    // Reset with two beats in flight.
    sel = 2'd0;
    @(negedge clk);
    out_ready = 1'b0;
    send_rand();
    send_rand();
    @(negedge clk);
    #3;
    rst_n = 1'b0;
    #1;
    chk("midrst_valid", 64'(o_valid), 64'd0);
    chk("midrst_val", o_val, 64'd0);
    chk("midrst_flags", 64'(o_fl), 64'd0);
    expq.delete();
    @(negedge clk);
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int c = 0; c < 4; c++) begin
      @(negedge clk);
      #3;
      chk("postrst_valid", 64'(o_valid), 64'd0);
      chk("postrst_in_ready", 64'(o_ready), 64'd1);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/add_pg_pipe.md
# add_pg_pipe

Parametrised, pipelined successor to the 32-bit group propagate/generate adder. Computes `val1 + val2 + carry_in` or `val1 - val2` over a configurable word width, split into `STAGES` equal lookahead slices with one register boundary per slice. Inputs and outputs use valid/ready handshakes, so the block drops into the datapath between handshaked producers and consumers. It also reports word-level propagate/generate, signed overflow and a zero flag.

## Interface
- `WIDTH`, default 32: operand width; must be a multiple of `STAGES`.
- `STAGES`, default 2: pipeline depth and slice count. Each slice is `WIDTH/STAGES` bits. Legal range is 1..WIDTH.
- `clk` input 1: single clock; all state updates on the rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `in_valid` input 1: operand beat offered.
- `in_ready` output 1: block accepts the beat this cycle.
- `val1`, `val2` input WIDTH: operands.
- `carry_in` input 1: carry in; with `sub=1` it acts as borrow-in, inverted.
- `sub` input 1: 0 = add, 1 = subtract.
- `out_valid` output 1: result beat present.
- `out_ready` input 1: consumer takes the beat.
- `val_out` output WIDTH: sum or difference.
- `carry_out` output 1: carry out of the MSB. In subtract mode, 1 means no borrow.
- `overflow` output 1: signed two's-complement overflow.
- `zero` output 1: `val_out == 0`.
- `prop_out`, `gen_out` output 1: word-level group P/G of the effective operands.

## Operation
- Effective operands: `b = val2 ^ {WIDTH{sub}}`, `c0 = carry_in ^ sub`. The block computes `val1 + b + c0`.
- Per-bit `p = a ^ b`, `g = a & b`. Each slice forms its group P/G with lookahead.
- Slice carry: `c_k+1 = G_k | P_k & c_k`.
- Word P/G accumulate across slices: `P = P_hi & P_lo`, `G = G_hi | P_hi & G_lo`.
- Pipeline stage k (1..STAGES) does the following:
  - Computes slice k-1 from the registered carry.
  - Passes forward the unprocessed upper operand bits, the completed lower result bits, and the running P/G.
- `overflow = (a[MSB] == b[MSB]) & (val_out[MSB] != a[MSB])`, using effective `b`.
- `zero` is computed in the final stage from the full result.
- Each stage holds one valid bit. `ready_k = ~valid_k | ready_k+1`, with `ready_STAGES+1 = out_ready`, and `in_ready = ready_1`.
  - This collapses bubbles.
  - It creates a combinational path from `out_ready` to `in_ready`, which is permitted.
- Stage k loads when `ready_k` is high. Its valid bit takes the upstream valid, which is `in_valid` for stage 1.
- Ordering is strictly FIFO. No beat is dropped or duplicated.
- `STAGES=1`: the whole word is computed combinationally into a single output register.

## Timing
- Reset (`rst_n` low, asynchronous): all valid bits clear, so `out_valid` = 0 immediately.
  - All data registers clear, so `val_out`, `carry_out`, `overflow`, `zero`, `prop_out` and `gen_out` are all 0.
  - `in_ready` = 1 once reset is released; it follows from the valid bits being 0.
- Latency: a beat accepted at edge N appears with `out_valid=1` after edge N+STAGES-1, i.e. STAGES cycles counting the accept edge, when there is no stall.
- Throughput is one beat per cycle while `out_ready` stays high.
- While `out_valid & ~out_ready`, every output holds stable.
- A stalled pipeline holds at most STAGES beats. `in_ready` falls only when all stages are valid and `out_ready` is 0.
- Simultaneous accept and emit in the same cycle on a full pipeline is legal and loses nothing.
- Reset mid-operation discards all in-flight beats. No partial result is emitted.
- Width rules:
  - `val_out` is exactly WIDTH bits; the carry goes only to `carry_out`.
  - `prop_out` and `gen_out` are independent of `c0`.

## Test plan
- WIDTH=32, STAGES=2, add, `0xFFFFFFFF + 0x00000001`, `carry_in=0` -> `val_out=0x00000000`, `carry_out=1`, `zero=1`, `overflow=0`, `prop_out=0`, `gen_out=1`; `out_valid` rises 2 cycles after accept.
- Cross-slice carry: `0x0000FFFF + 0x00000001` -> `0x00010000`, `carry_out=0`. Also `0x00000000 + 0xFFFFFFFF` with `carry_in=1` -> `0x00000000`, `carry_out=1`, `prop_out=1`.
- Subtract: `sub=1`, `carry_in=0`, `5 - 7` -> `val_out=0xFFFFFFFE`, `carry_out=0`, `overflow=0`. Then `0x80000000 - 1` -> `0x7FFFFFFF`, `overflow=1`, `carry_out=1`.
- Signed overflow on add: `0x7FFFFFFF + 1` -> `0x80000000`, `overflow=1`, `carry_out=0`.
- Backpressure: four back-to-back beats with `out_ready=0` for 4 cycles.
  - `in_ready` drops after the 2nd beat is held.
  - Outputs remain stable during the stall.
  - After `out_ready=1`, all four results emerge in order with no loss.
  - Repeat with STAGES=1 and STAGES=4, WIDTH=64.
- Reset mid-flight: assert `rst_n=0` with 2 beats in flight -> `out_valid=0` and all outputs 0 without waiting for a clock edge. After release, no stale beat is emitted and `in_ready=1`.
